serial_tx_scheduler: RTL and testbench
======================================

# serial_tx_scheduler

Round-robin scheduler that shares one `serializer` instance (MSG_SIZE-bit parallel-in, MSB-first serial-out) between N_REQ message sources. It grants one requester at a time and latches its message. It then sequences the serializer through reset, load, run and completion. Each requester gets a done or error acknowledgement, followed by a programmable inter-frame gap. It sits between the message producers and the serializer and owns all of the serializer's control inputs.

## Interface
- MSG_SIZE, 64, message width in bits; must match the serializer.
- N_REQ, 2, number of requesters (2..8).
- GAP_CYCLES, 2, idle cycles between frames (0 allowed).
- TIMEOUT, 8, maximum RUN cycles waiting for `ser_flag` to rise (≥1).
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester transmit request, level.
- msg_in  in  N_REQ*MSG_SIZE  messages; requester i occupies bits [i*MSG_SIZE +: MSG_SIZE].
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with `ack` when the frame failed.
- busy  out  1  high in every state except IDLE.
- active_id  out  max(1,$clog2(N_REQ))  index of the current or last grant.
- ser_data  out  MSG_SIZE  drives serializer `iData_in`.
- ser_counter  out  $clog2(MSG_SIZE)+1  drives serializer `iCounter`.
- ser_ena  out  1  drives serializer `ena`.
- ser_rst_n  out  1  drives serializer `rst_n`, active-low.
- ser_flag  in  1  serializer `oData_flag`.

## Operation
- All outputs are Moore-registered and are functions of state only.
- States: IDLE, LOAD, RUN, SHIFT, DONE, GAP.
- IDLE
  - If any `req` is set, pick the winner round-robin: first set bit searching upward from (last_grant+1) mod N_REQ, with wrap-around.
  - Latch the winner's message into `ser_data`, set `active_id`, update last_grant, and go to LOAD.
- LOAD: go to RUN unconditionally. This state gives `ser_data` one stable cycle while the serializer is still held in reset.
- RUN
  - `ser_rst_n`=1, `ser_ena`=1, `ser_counter`=MSG_SIZE.
  - If `ser_flag`=1: bitcnt←1, go to SHIFT.
  - Otherwise increment the timeout counter; when it reaches TIMEOUT, go to DONE with error.
- SHIFT
  - Same serializer drive as RUN.
  - If `ser_flag`=1: bitcnt++. If bitcnt would exceed MSG_SIZE, go to DONE with error.
  - If `ser_flag`=0: go to DONE. The frame is an error if bitcnt≠MSG_SIZE.
- DONE
  - `ack[active_id]`=1 for exactly one cycle; `err` is set if an error was flagged.
  - Go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: hold for GAP_CYCLES cycles, then go to IDLE.
- Serializer drive outside RUN/SHIFT: `ser_rst_n`=0, `ser_ena`=0, `ser_counter`=0. The serializer is held in reset whenever it is not transmitting, which re-arms its one-shot done latch for every frame.
- `ser_data` holds its latched value from grant until the next grant; changes on `msg_in` after the grant are ignored.
- If `req` drops mid-frame, the frame still completes and `ack` still pulses.
- A requester holding `req` through `ack` is re-queued. Other pending requesters win first.
- Counter widths:
  - bitcnt is $clog2(MSG_SIZE+2) bits and must not wrap before the overflow check.
  - The timeout counter is $clog2(TIMEOUT+1) bits.
  - Both counters clear in LOAD.

## Timing
- Reset values (any cycle with `rst`=1 → IDLE next edge):
  - ack=0, err=0, busy=0, active_id=0, last_grant=N_REQ-1 (so requester 0 has first priority).
  - ser_data=0, ser_counter=0, ser_ena=0, ser_rst_n=0.
- Reset mid-frame aborts the frame immediately with no `ack`.
- Nominal frame, with the request seen in IDLE at t0:
  - t1 LOAD, t2 RUN.
  - Serializer flag high t3..t3+MSG_SIZE-1, low at t3+MSG_SIZE.
  - `ack` at t4+MSG_SIZE (t68 for MSG_SIZE=64).
  - GAP t69..t70, IDLE t71, next LOAD no earlier than t72.
- Grant-to-ack latency is MSG_SIZE+4 cycles. Back-to-back frame period is MSG_SIZE+5+GAP_CYCLES.
- Timeout: flag never rises → `ack`+`err` at t2+TIMEOUT+1.

## Test plan
- Single request: req=01, msg0=64'hA5A5_0000_FFFF_1234 → serial stream MSB-first matches msg0; ack=01 at t68, err=0; busy high t1..t70.
- Contention: req=11 held continuously → grants alternate 0,1,0,1; each `ack` is the one-hot of `active_id`; frames spaced exactly 71 cycles apart (71 = MSG_SIZE+5+GAP_CYCLES).
- Data stability: change msg_in and drop `req` at t10 of a frame → transmitted bits equal the value latched at grant; ack still pulses at t68.
- Timeout: model `ser_flag` stuck at 0 → `ack` and `err` both pulse at t11 (TIMEOUT=8); the next frame proceeds normally.
- Bit-count error: flag held high 65 cycles → err=1 in DONE; flag high only 63 cycles → err=1; flag high 64 cycles → err=0.
- Reset mid-frame: assert rst at t30 → next cycle all outputs at reset values, no `ack`; a new req=10 then gets a grant to requester 1 and a clean frame.

Source files
------------

// File: rtl/serial_tx_scheduler_if.sv
// serial_tx_scheduler_if: requester handshake and serializer control bundle of the scheduler
interface serial_tx_scheduler_if #(
    parameter int MSG_SIZE = 64,
    parameter int N_REQ = 2
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MSG_SIZE) + 1;
    logic [N_REQ-1:0] req;
    logic [N_REQ*MSG_SIZE-1:0] msg_in;
    logic [N_REQ-1:0] ack;
    logic err;
    logic busy;
    logic [IW-1:0] active_id;
    logic [MSG_SIZE-1:0] ser_data;
    logic [CW-1:0] ser_counter;
    logic ser_ena;
    logic ser_rst_n;
    logic ser_flag;
    modport master (
        output req, msg_in, ser_flag,
        input ack, err, busy, active_id, ser_data, ser_counter, ser_ena, ser_rst_n
    );
    modport slave (
        input req, msg_in, ser_flag,
        output ack, err, busy, active_id, ser_data, ser_counter, ser_ena, ser_rst_n
    );
endinterface

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin arbiter sequencing one shared serializer through load, run and ack
module serial_tx_scheduler #(
    parameter int MSG_SIZE = 64,
    parameter int N_REQ = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT = 8
) (
    input logic clk,
    input logic rst,
    serial_tx_scheduler_if.slave bus
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam int BW = $clog2(MSG_SIZE + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, SHIFT, DONE, GAP} state_t;
    state_t state, state_n;
    logic [IW-1:0] last_grant, active_id, winner, idx;
    logic found, fail, fail_n, run_on;
    logic [MSG_SIZE-1:0] data;
    logic [BW-1:0] bitcnt, bitcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    // first pending requester strictly after the last grant, wrapping around
    always_comb begin
        winner = last_grant;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(last_grant) + k) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                winner = idx;
            end
        end
    end
    always_comb begin
        state_n = state;
        bitcnt_n = bitcnt;
        tcnt_n = tcnt;
        gcnt_n = gcnt;
        fail_n = fail;
        case (state)
            IDLE: state_n = found ? LOAD : IDLE;
            LOAD: begin
                state_n = RUN;
                bitcnt_n = '0;
                tcnt_n = '0;
                fail_n = 1'b0;
            end
            RUN: begin
                if (bus.ser_flag) begin
                    bitcnt_n = BW'(1);
                    state_n = SHIFT;
                end else if (tcnt == TW'(TIMEOUT)) begin
                    state_n = DONE;
                    fail_n = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            SHIFT: begin
                if (bus.ser_flag && bitcnt == BW'(MSG_SIZE)) begin
                    state_n = DONE;
                    fail_n = 1'b1;
                end else if (bus.ser_flag) begin
                    bitcnt_n = bitcnt + 1'b1;
                end else begin
                    state_n = DONE;
                    fail_n = bitcnt != BW'(MSG_SIZE);
                end
            end
            DONE: begin
                state_n = GAP_CYCLES == 0 ? IDLE : GAP;
                gcnt_n = '0;
            end
            GAP: begin
                state_n = gcnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
                gcnt_n = gcnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= IW'(N_REQ - 1);
            active_id <= '0;
            data <= '0;
            bitcnt <= '0;
            tcnt <= '0;
            gcnt <= '0;
            fail <= 1'b0;
        end else begin
            state <= state_n;
            bitcnt <= bitcnt_n;
            tcnt <= tcnt_n;
            gcnt <= gcnt_n;
            fail <= fail_n;
            if (state == IDLE && found) begin
                last_grant <= winner;
                active_id <= winner;
                data <= bus.msg_in[winner*MSG_SIZE +: MSG_SIZE];
            end
        end
    end
    // serializer stays in reset outside RUN/SHIFT so its done latch re-arms every frame
    assign run_on = state == RUN || state == SHIFT;
    assign bus.ser_rst_n = run_on;
    assign bus.ser_ena = run_on;
    assign bus.ser_counter = run_on ? CW'(MSG_SIZE) : '0;
    assign bus.ser_data = data;
    assign bus.active_id = active_id;
    assign bus.busy = state != IDLE;
    assign bus.ack = state == DONE ? N_REQ'(1) << active_id : '0;
    assign bus.err = state == DONE && fail;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: vector table, corner sequences and a random run against a frame-level model
module tb_serial_tx_scheduler;
    localparam int MS = 64, NR = 2, GAP = 2, TO = 8;
    localparam int IW = NR > 1 ? $clog2(NR) : 1;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    serial_tx_scheduler_if #(.MSG_SIZE(MS), .N_REQ(NR)) bus ();
    serial_tx_scheduler #(.MSG_SIZE(MS), .N_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    int checks = 0, errors = 0;
    int cyc = 0, flag_len = MS;
    logic [MS-1:0] stream = '0;
    // serializer stand-in: flag high for flag_len cycles starting one cycle after release, MSB first
    assign bus.ser_flag = bus.ser_rst_n && cyc >= 1 && cyc <= flag_len;
    always @(posedge clk) begin
        if (!bus.ser_rst_n) begin
            cyc <= 0;
            stream <= '0;
        end else begin
            cyc <= cyc + 1;
            if (bus.ser_flag && cyc <= MS) stream[MS-cyc] <= bus.ser_data[MS-cyc];
        end
    end
    typedef struct {
        logic [NR-1:0] r;
        logic [MS-1:0] m;
        int len;
        int id;
        logic e;
        int lat;
    } vec_t;
    vec_t tbl [8];
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask
    function automatic logic [NR-1:0] oh(input int i);
        return NR'(1) << i;
    endfunction
    task automatic check_reset(input string name);
        check(name, 128'({bus.ack, bus.err, bus.busy, bus.active_id, bus.ser_data, bus.ser_counter,
                          bus.ser_ena, bus.ser_rst_n}), 128'(0));
    endtask
    task automatic wait_idle(input string name);
        for (int w = 0; w < 200 && bus.busy; w++) step();
        check({name, " idle"}, 128'(bus.busy), 128'(0));
    endtask
    task automatic run_frame(input string name, input logic [NR-1:0] r, input logic [MS-1:0] m,
                             input int len, input int id, input logic e, input int lat);
        int n;
        n = 0;
        wait_idle(name);
        bus.req = r;
        bus.msg_in = {NR{~m}};
        bus.msg_in[id*MS +: MS] = m;
        flag_len = len;
        while (n < 200 && bus.ack == '0) begin
            step();
            n++;
            if (n == 1)
                check({name, " t1"}, 128'({bus.busy, bus.ser_rst_n, bus.ser_ena, bus.ser_counter}), 128'({1'b1, 9'd0}));
            if (n == 2)
                check({name, " t2"}, 128'({bus.ser_rst_n, bus.ser_ena, bus.ser_counter}), 128'({2'b11, 7'(MS)}));
            // late input changes must not reach the frame in flight
            if (n == 10) begin
                bus.msg_in = ~bus.msg_in;
                bus.req = '0;
            end
        end
        check({name, " latency"}, 128'(n), 128'(lat));
        check({name, " ack"}, 128'({bus.ack, bus.err, bus.active_id, bus.ser_data}), 128'({oh(id), e, IW'(id), m}));
        if (len >= MS) check({name, " stream"}, 128'(stream), 128'(m));
        step();
        check({name, " pulse"}, 128'({bus.ack, bus.err}), 128'(0));
    endtask
    initial begin
        int last, k, acks, t, free_at, grant_t, ack_at, aid, len, lat, id;
        logic e_exp;
        logic [MS-1:0] m_exp;
        logic [NR-1:0] exp_ack;
        bus.req = '0;
        bus.msg_in = '0;
        reset_dut();
        check_reset("reset");
        tbl[0] = '{2'b01, 64'hA5A5_0000_FFFF_1234, MS, 0, 1'b0, MS + 4};
        tbl[1] = '{2'b11, 64'h0123_4567_89AB_CDEF, MS, 1, 1'b0, MS + 4};
        tbl[2] = '{2'b11, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b1, TO + 3};
        tbl[3] = '{2'b11, 64'h8000_0000_0000_0001, MS + 1, 1, 1'b1, MS + 4};
        tbl[4] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, MS - 1, 0, 1'b1, MS + 3};
        tbl[5] = '{2'b10, 64'h1357_9BDF_0246_8ACE, MS, 1, 1'b0, MS + 4};
        tbl[6] = '{2'b10, 64'h0, MS, 1, 1'b0, MS + 4};
        tbl[7] = '{2'b01, 64'h5555_AAAA_5555_AAAA, 1, 0, 1'b1, 5};
        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].r, tbl[i].m, tbl[i].len, tbl[i].id, tbl[i].e, tbl[i].lat);
        // contention: both requesters held, grants alternate from requester 0
        bus.req = '0;
        reset_dut();
        bus.req = '1;
        bus.msg_in = {$urandom, $urandom, $urandom, $urandom};
        flag_len = MS;
        last = 0;
        k = 0;
        for (int n = 1; n <= 400 && k < 4; n++) begin
            step();
            if (bus.ack != '0) begin
                check("rr id", 128'(bus.active_id), 128'(k % NR));
                check("rr onehot", 128'(bus.ack), 128'(oh(int'(bus.active_id))));
                check("rr spacing", 128'(n - last), 128'(k == 0 ? MS + 4 : MS + 5 + GAP));
                last = n;
                k++;
            end
        end
        check("rr frames", 128'(k), 128'(4));
        // reset in the middle of a frame
        bus.req = '0;
        wait_idle("midrst");
        bus.req = NR'(1);
        bus.msg_in = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 30; n++) step();
        rst = 1'b1;
        bus.req = '0;
        step();
        check_reset("midrst outputs");
        rst = 1'b0;
        acks = 0;
        for (int n = 0; n < 80; n++) begin
            step();
            if (bus.ack != '0) acks++;
        end
        check("midrst no ack", 128'(acks), 128'(0));
        run_frame("post reset", 2'b10, 64'hC3C3_1111_2222_3C3C, MS, 1, 1'b0, MS + 4);
        // random traffic against a frame-level model
        bus.req = '0;
        reset_dut();
        t = 0;
        free_at = 0;
        grant_t = -1;
        ack_at = -1;
        last = NR - 1;
        aid = 0;
        e_exp = 1'b0;
        m_exp = '0;
        len = MS;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.req = NR'($urandom);
            bus.msg_in = {$urandom, $urandom, $urandom, $urandom};
            if (t >= free_at && bus.req != '0) begin
                id = -1;
                for (int j = NR; j >= 1; j--) if (bus.req[(last + j) % NR]) id = (last + j) % NR;
                last = id;
                aid = id;
                m_exp = bus.msg_in[id*MS +: MS];
                case ($urandom_range(0, 9))
                    6: len = 0;
                    7: len = MS - 1;
                    8: len = MS + 1;
                    9: len = int'($urandom_range(1, MS + 6));
                    default: len = MS;
                endcase
                flag_len = len;
                lat = len == 0 ? TO + 3 : 4 + (len < MS ? len : MS);
                e_exp = len != MS;
                grant_t = t;
                ack_at = t + lat;
                free_at = ack_at + GAP + 1;
            end
            step();
            t++;
            exp_ack = t == ack_at ? oh(aid) : NR'(0);
            check("rand ctl", 128'({bus.ack, bus.err, bus.busy, bus.active_id}),
                  128'({exp_ack, t == ack_at && e_exp, grant_t >= 0 && t > grant_t && t < free_at, IW'(aid)}));
            if (t == ack_at) begin
                check("rand data", 128'(bus.ser_data), 128'(m_exp));
                if (len >= MS) check("rand stream", 128'(stream), 128'(m_exp));
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
